// File: rtl/stall_flush_ctrl.sv
// Central hazard controller for the 5-stage MIPS pipeline.
// Produces PC / F/D enables and F/D, D/E, E/M flushes from Tuse/Tnew data
// hazards, a mult/div busy countdown and the stage-M exception request.
module stall_flush_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic       d_is_md,
    input  logic [4:0] e_wa,
    input  logic [1:0] e_tnew,
    input  logic [4:0] m_wa,
    input  logic [1:0] m_tnew,
    input  logic       e_md_start,
    input  logic       e_md_div,
    input  logic       m_exc_req,
    output logic       pc_en,
    output logic       fd_en,
    output logic       fd_flush,
    output logic       de_flush,
    output logic       em_flush,
    output logic       md_busy
);

    logic [CNT_W-1:0] cnt;
    logic             cnt_nz;
    logic             stall_rs;
    logic             stall_rt;
    logic             stall_md;
    logic             stall;

    assign cnt_nz = (cnt != '0);

    // Busy countdown: loads on an accepted mult/div start, then runs down to zero.
    // A start seen while counting is ignored; an exception blocks a new start
    // but never cancels a count already in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (e_md_start && !m_exc_req && !cnt_nz) begin
            cnt <= e_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (cnt_nz) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Hazard detection: a source stalls when its producer in E or M delivers
    // later than the consumer needs it. Tuse=3 can never be below a 2-bit Tnew.
    always_comb begin
        stall_rs = (d_rs != '0) &&
                   (((d_rs == e_wa) && (d_tuse_rs < e_tnew)) ||
                    ((d_rs == m_wa) && (d_tuse_rs < m_tnew)));
        stall_rt = (d_rt != '0) &&
                   (((d_rt == e_wa) && (d_tuse_rt < e_tnew)) ||
                    ((d_rt == m_wa) && (d_tuse_rt < m_tnew)));
        stall_md = d_is_md && (e_md_start || cnt_nz);
        stall    = stall_rs || stall_rt || stall_md;
    end

    // Output decode: reset forces a full flush, exception overrides stall.
    always_comb begin
        pc_en    = 1'b1;
        fd_en    = 1'b1;
        fd_flush = 1'b0;
        de_flush = 1'b0;
        em_flush = 1'b0;
        md_busy  = reset && cnt_nz;
        if (!reset) begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            fd_flush = 1'b1;
            de_flush = 1'b1;
            em_flush = 1'b1;
        end else if (m_exc_req) begin
            fd_flush = 1'b1;
            de_flush = 1'b1;
            em_flush = 1'b1;
        end else if (stall) begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            de_flush = 1'b1;
        end
    end

endmodule

// File: tb/tb_stall_flush_ctrl.sv
// Self-checking bench for stall_flush_ctrl: constant vector table, directed
// multi-cycle sequences and random stimulus against a cycle-indexed model.
module tb_stall_flush_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic       clk;
    logic       reset;
    logic [4:0] d_rs, d_rt, e_wa, m_wa;
    logic [1:0] d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
    logic       d_is_md, e_md_start, e_md_div, m_exc_req;
    logic       pc_en, fd_en, fd_flush, de_flush, em_flush, md_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;          // index of the current cycle
    int busy_until = 0;   // md unit busy in cycles with index < busy_until
    int busy_seen = 0;

    stall_flush_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_is_md(d_is_md), .e_wa(e_wa), .e_tnew(e_tnew), .m_wa(m_wa), .m_tnew(m_tnew),
        .e_md_start(e_md_start), .e_md_div(e_md_div), .m_exc_req(m_exc_req),
        .pc_en(pc_en), .fd_en(fd_en), .fd_flush(fd_flush), .de_flush(de_flush),
        .em_flush(em_flush), .md_busy(md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] tuse_rs;
        logic [1:0] tuse_rt;
        logic       is_md;
        logic [4:0] ewa;
        logic [1:0] etnew;
        logic [4:0] mwa;
        logic [1:0] mtnew;
        logic       exc;
        logic [4:0] exp;   // {pc_en, fd_en, fd_flush, de_flush, em_flush}
    } vec_t;

    vec_t vecs[10];

    // Does a consumer needing reg in 'need' cycles wait on a producer?
    function automatic bit waits(input int r, input int need, input int wa, input int tnew);
        return (r != 0) && (r == wa) && (need < tnew);
    endfunction

    function automatic logic [5:0] model_out();
        bit busy, stall;
        if (!reset) return 6'b001110;
        busy  = (cyc < busy_until);
        stall = waits(d_rs, d_tuse_rs, e_wa, e_tnew) || waits(d_rs, d_tuse_rs, m_wa, m_tnew) ||
                waits(d_rt, d_tuse_rt, e_wa, e_tnew) || waits(d_rt, d_tuse_rt, m_wa, m_tnew) ||
                (d_is_md && (e_md_start || busy));
        if (m_exc_req) return {5'b11111, busy};
        if (stall)     return {5'b00010, busy};
        return {5'b11000, busy};
    endfunction

    task automatic check_eq(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_out(input string name);
        logic [5:0] got, exp;
        got = {pc_en, fd_en, fd_flush, de_flush, em_flush, md_busy};
        exp = model_out();
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cyc=%0d t=%0t)", name, got, exp, cyc, $time);
        end
    endtask

    // Called at posedge+1: check at negedge, advance model across the edge.
    task automatic step(input string name);
        #4;
        check_out(name);
        if (md_busy) busy_seen++;
        if (!reset) busy_until = 0;
        else if (e_md_start && !m_exc_req && !(cyc < busy_until))
            busy_until = cyc + 1 + (e_md_div ? DIV_N : MULT_N);
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle();
        d_rs = '0; d_rt = '0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3; d_is_md = 1'b0;
        e_wa = '0; e_tnew = '0; m_wa = '0; m_tnew = '0;
        e_md_start = 1'b0; e_md_div = 1'b0; m_exc_req = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        vecs[0] = '{5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 5'b11000};
        vecs[1] = '{5'd5, 5'd0, 2'd0, 2'd3, 1'b0, 5'd5, 2'd1, 5'd0, 2'd0, 1'b0, 5'b00010};
        vecs[2] = '{5'd0, 5'd0, 2'd0, 2'd3, 1'b0, 5'd5, 2'd1, 5'd0, 2'd0, 1'b0, 5'b11000};
        vecs[3] = '{5'd5, 5'd0, 2'd1, 2'd3, 1'b0, 5'd5, 2'd1, 5'd0, 2'd0, 1'b0, 5'b11000};
        vecs[4] = '{5'd0, 5'd7, 2'd3, 2'd1, 1'b0, 5'd0, 2'd0, 5'd7, 2'd2, 1'b0, 5'b00010};
        vecs[5] = '{5'd0, 5'd7, 2'd3, 2'd3, 1'b0, 5'd7, 2'd3, 5'd7, 2'd3, 1'b0, 5'b11000};
        vecs[6] = '{5'd9, 5'd0, 2'd0, 2'd3, 1'b0, 5'd9, 2'd1, 5'd0, 2'd0, 1'b1, 5'b11111};
        vecs[7] = '{5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 5'b11111};
        vecs[8] = '{5'd4, 5'd0, 2'd0, 2'd3, 1'b0, 5'd4, 2'd0, 5'd0, 2'd0, 1'b0, 5'b11000};
        vecs[9] = '{5'd3, 5'd3, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0, 5'd3, 2'd1, 1'b0, 5'b00010};

        @(posedge clk); cyc++; #1;

        // Reset held for 3 cycles, then released with idle inputs.
        for (int i = 0; i < 3; i++) step("reset_hold");
        reset = 1'b1;
        step("reset_release");
        #4;
        check_eq("idle_pc_en", pc_en, 1);
        check_eq("idle_flushes", {fd_flush, de_flush, em_flush}, 0);
        @(posedge clk); cyc++; #1;

        // Constant vector table (counter idle).
        for (int i = 0; i < 10; i++) begin
            d_rs = vecs[i].rs; d_rt = vecs[i].rt;
            d_tuse_rs = vecs[i].tuse_rs; d_tuse_rt = vecs[i].tuse_rt;
            d_is_md = vecs[i].is_md; e_wa = vecs[i].ewa; e_tnew = vecs[i].etnew;
            m_wa = vecs[i].mwa; m_tnew = vecs[i].mtnew; m_exc_req = vecs[i].exc;
            #4;
            check_eq($sformatf("vec%0d", i),
                     {pc_en, fd_en, fd_flush, de_flush, em_flush}, vecs[i].exp);
            check_eq($sformatf("vec%0d_busy", i), md_busy, 0);
            @(posedge clk); cyc++; #1;
        end
        idle();

        // mult with d_is_md held: stall in start cycle, 5 busy cycles.
        d_is_md = 1'b1; e_md_start = 1'b1; e_md_div = 1'b0; busy_seen = 0;
        step("mult_start");
        e_md_start = 1'b0;
        for (int i = 0; i < 5; i++) step("mult_busy");
        #4;
        check_eq("mult_release_pc_en", pc_en, 1);
        @(posedge clk); cyc++; #1;
        for (int i = 0; i < 2; i++) step("mult_tail");
        check_eq("mult_busy_len", busy_seen, MULT_N);

        // div: 10 busy cycles.
        e_md_start = 1'b1; e_md_div = 1'b1; busy_seen = 0;
        step("div_start");
        e_md_start = 1'b0;
        for (int i = 0; i < 12; i++) step("div_run");
        check_eq("div_busy_len", busy_seen, DIV_N);
        idle();

        // Exception with data hazard, and with a md start that must be dropped.
        d_rs = 5'd6; d_tuse_rs = 2'd0; e_wa = 5'd6; e_tnew = 2'd2; m_exc_req = 1'b1;
        step("exc_over_stall");
        e_md_start = 1'b1; e_md_div = 1'b1;
        step("exc_md_start");
        idle();
        #4;
        check_eq("exc_no_count", md_busy, 0);
        @(posedge clk); cyc++; #1;

        // Reset in the middle of a div countdown.
        e_md_start = 1'b1; e_md_div = 1'b1;
        step("rst_div_start");
        e_md_start = 1'b0;
        for (int i = 0; i < 3; i++) step("rst_div_run");
        #2;
        check_eq("rst_pre_busy", md_busy, 1);
        reset = 1'b0;
        #1;
        check_eq("rst_async_busy", md_busy, 0);
        check_eq("rst_async_pc_en", pc_en, 0);
        busy_until = 0;
        @(posedge clk); cyc++; #1;
        step("rst_hold");
        reset = 1'b1; d_is_md = 1'b1;
        step("rst_after_md");
        idle();

        // Second start at cnt=3 is ignored; original 10-cycle count stands.
        e_md_start = 1'b1; e_md_div = 1'b1; busy_seen = 0;
        step("restart_start");
        e_md_start = 1'b0;
        for (int i = 0; i < 7; i++) step("restart_run");
        e_md_start = 1'b1; e_md_div = 1'b0;
        step("restart_pulse");
        e_md_start = 1'b0;
        for (int i = 0; i < 5; i++) step("restart_tail");
        check_eq("restart_busy_len", busy_seen, DIV_N);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            d_rs = 5'($urandom_range(0, 3)); d_rt = 5'($urandom_range(0, 3));
            d_tuse_rs = 2'($urandom); d_tuse_rt = 2'($urandom);
            d_is_md = 1'($urandom_range(0, 2) == 0);
            e_wa = 5'($urandom_range(0, 3)); e_tnew = 2'($urandom);
            m_wa = 5'($urandom_range(0, 3)); m_tnew = 2'($urandom);
            e_md_start = 1'($urandom_range(0, 5) == 0);
            e_md_div = 1'($urandom);
            m_exc_req = 1'($urandom_range(0, 9) == 0);
            reset = (i < 200) ? 1'b1 : 1'($urandom_range(0, 49) != 0);
            step("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stall_flush_ctrl.md
Name: stall_flush_ctrl

Overview:
- Central hazard controller for the 5-stage MIPS pipeline. Drives the enable and flush inputs of the PC and the F/D, D/E and E/M pipeline registers.
- Detects data hazards from Tuse/Tnew comparison and tracks mult/div busy time with an internal counter.
- Turns a stage-M exception/interrupt request into a pipeline flush.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu leaves E.
- DIV_CYCLES, 10, busy cycles after a div/divu leaves E.
- CNT_W, 4, busy counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- d_rs  input  5  rs address of instruction in D.
- d_rt  input  5  rt address of instruction in D.
- d_tuse_rs  input  2  cycles until D needs rs; 3 = not used.
- d_tuse_rt  input  2  same for rt.
- d_is_md  input  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- e_wa  input  5  destination register of E instruction; 0 = none.
- e_tnew  input  2  cycles until E result is available.
- m_wa  input  5  destination register of M instruction.
- m_tnew  input  2  cycles until M result is available.
- e_md_start  input  1  mult/div instruction is in E this cycle.
- e_md_div  input  1  qualifies e_md_start: 1 = div, 0 = mult.
- m_exc_req  input  1  exception/interrupt taken at M.
- pc_en  output  1  PC write enable.
- fd_en  output  1  F/D register enable.
- fd_flush  output  1  F/D synchronous clear, active-high.
- de_flush  output  1  D/E synchronous clear; inserts a bubble.
- em_flush  output  1  E/M synchronous clear.
- md_busy  output  1  busy counter non-zero.

Behaviour:
- State: busy counter cnt[CNT_W-1:0] is the only storage. All outputs are combinational from cnt and the inputs.
- Reset (reset=0, asynchronous): cnt=0. While reset is low, all outputs are forced: pc_en=0, fd_en=0, fd_flush=1, de_flush=1, em_flush=1, md_busy=0.
- Data hazard on rs: stall_rs = (d_rs!=0) && ((d_rs==e_wa && d_tuse_rs<e_tnew) || (d_rs==m_wa && d_tuse_rs<m_tnew)). stall_rt is the same using d_rt and d_tuse_rt.
  - A Tuse of 3 never stalls.
  - Register 0 never stalls.
- MD hazard: stall_md = d_is_md && (e_md_start || cnt!=0).
- stall = stall_rs | stall_rt | stall_md.
- Counter update at each rising edge:
  - If e_md_start && !m_exc_req && cnt==0: load DIV_CYCLES if e_md_div, else MULT_CYCLES.
  - Else if cnt!=0: decrement by 1.
  - Else hold 0.
  - e_md_start while cnt!=0 is a protocol violation: ignored, countdown continues.
  - cnt never wraps below 0.
- md_busy = (cnt!=0). It is high for exactly N consecutive cycles, starting the cycle after e_md_start.
- Normal (no stall, no exception): pc_en=1, fd_en=1, all flush outputs 0.
- Stall (no exception): pc_en=0, fd_en=0, de_flush=1, fd_flush=0, em_flush=0.
- Exception (m_exc_req=1) overrides stall:
  - pc_en=1 (the handler vector loads), fd_en=1.
  - fd_flush=1, de_flush=1, em_flush=1.
  - No new md start is accepted. An already-running count continues; HI/LO completion is not cancelled.
- Simultaneous stall_md and counter expiry (cnt==1): stall is asserted this cycle and released next cycle when cnt==0.
- Reset mid-count: cnt clears immediately and md_busy drops asynchronously.
- Latency: hazard outputs are zero-cycle (same cycle as inputs). The counter effect lags e_md_start by one edge.

Test Plan:
- Reset held low for 3 cycles, then released -> during reset pc_en=0, all flushes=1; after release with idle inputs pc_en=1, fd_en=1, flushes=0, md_busy=0.
- d_rs=5, d_tuse_rs=0, e_wa=5, e_tnew=1 (load-use) -> pc_en=0, fd_en=0, de_flush=1. Repeat with d_rs=0 -> no stall. Repeat with d_tuse_rs=1 -> no stall.
- e_md_start=1, e_md_div=0 for one cycle, with d_is_md=1 held -> stall in start cycle, md_busy=1 for exactly 5 cycles, stall releases on cycle 6. Same with e_md_div=1 -> 10 busy cycles.
- m_exc_req=1 together with stall_rs=1 -> pc_en=1, fd_en=1, fd_flush=de_flush=em_flush=1. The same with e_md_start=1 leaves cnt at 0.
- Start a div, then assert reset at busy cycle 4 -> md_busy=0 immediately. After release, d_is_md=1 does not stall.
- Pulse e_md_start again at cnt=3 -> ignored; md_busy still ends after the original 10 cycles.
